mmio_bus_decoder: RTL and testbench

Parametrised successor of the single-peripheral I2C address decoder: maps a CPU load/store onto data memory or one of NUM_SLAVES register-mapped peripherals (I2C, timers, GPIO, ...). Adds a req/ready handshake, per-slave wait states with acknowledge, a bus-timeout counter, a write-protection mask, and a registered read-data return. Sits between the CPU memory stage and the data memory / peripheral register files.

---
 rtl/mmio_pkg.sv | 31 +++
 rtl/mmio_range_decode.sv | 32 +++
 rtl/mmio_bus_decoder.sv | 183 ++++++++++++++++++
 tb/tb_mmio_bus_decoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO decoder and its range-decode helper.
// Pure declarations: no latency, no flow control.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_SREQ = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int DEF_BASE_ADDR = 60;
  localparam int DEF_SPAN      = 4;

  // I2C register map inside slave 0's window
  localparam int I2C_TXD  = 0;
  localparam int I2C_CTRL = 1;
  localparam int I2C_STAT = 2;
  localparam int I2C_RXD  = 3;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

  function automatic int idx_width(input int span);
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  function automatic int slv_width(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/mmio_range_decode.sv
// Combinational Addr -> (hit, slave, idx) window decode; zero latency.
// No flow control; shared by the CPU port and the future DMA port.
module mmio_range_decode
  import mmio_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                NUM_SLAVES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
  parameter int                SPAN       = DEF_SPAN,
  parameter int                IDX_W      = idx_width(SPAN),
  parameter int                SLV_W      = slv_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [SLV_W-1:0]  slave_o,
  output logic [IDX_W-1:0]  idx_o
);

  localparam int              OFF_W = IDX_W + SLV_W;
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(NUM_SLAVES * SPAN);

  logic [OFF_W-1:0] off;

  // Upper bound compared one bit wider so a window ending at the top of the map cannot wrap.
  assign hit_o = (addr_i >= BASE_ADDR) && ({1'b0, addr_i} < LIMIT);

  // Only the low bits of the offset matter once hit is known, so subtract narrow.
  assign off     = addr_i[OFF_W-1:0] - BASE_ADDR[OFF_W-1:0];
  assign idx_o   = off[IDX_W-1:0];
  assign slave_o = off[IDX_W +: SLV_W];

endmodule

// File: rtl/mmio_bus_decoder.sv
// Routes a CPU load/store to data memory or a peripheral window; ready 1..TIMEOUT+1 cycles after accept.
// Requester holds req until the one-cycle ready pulse; peripherals stall via slv_ack, bounded by TIMEOUT.
module mmio_bus_decoder
  import mmio_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_SLAVES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
  parameter int                SPAN       = DEF_SPAN,
  parameter logic [SPAN-1:0]   RO_MASK    = SPAN'((1 << I2C_STAT) | (1 << I2C_RXD)),
  parameter int                TIMEOUT    = 15,
  parameter int                IDX_W      = idx_width(SPAN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic                         memWrite,
  input  logic [ADDR_W-1:0]            Addr,
  output logic                         ready,
  output logic                         err,
  output logic [DATA_W-1:0]            rdata,
  output logic                         WEM,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [NUM_SLAVES-1:0]        sel,
  output logic [NUM_SLAVES-1:0]        we,
  output logic [IDX_W-1:0]             reg_idx,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ack
);

  localparam int SLV_W = slv_width(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic              hit_w;
  logic [SLV_W-1:0]  slave_w;
  logic [IDX_W-1:0]  idx_w;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [SLV_W-1:0]  slave_q, slave_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              wem_q, wem_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [NUM_SLAVES-1:0] we_q, we_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;

  logic              ack_w;
  logic [DATA_W-1:0] sdata_w;

  mmio_range_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .SPAN       (SPAN),
    .IDX_W      (IDX_W),
    .SLV_W      (SLV_W)
  ) u_range_decode (
    .addr_i  (Addr),
    .hit_o   (hit_w),
    .slave_o (slave_w),
    .idx_o   (idx_w)
  );

  // Only the latched slave's ack and data are looked at; other slaves are ignored.
  assign ack_w   = slv_ack[slave_q];
  assign sdata_w = slv_rdata[slave_q*DATA_W +: DATA_W];
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    slave_d = slave_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = memWrite;
          slave_d = slave_w;
          idx_d   = idx_w;
          cnt_d   = '0;
          if (!hit_w) begin
            state_d = ST_MEM;
          end else if (memWrite && RO_MASK[idx_w]) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_SREQ;
          end
        end
      end
      ST_MEM: begin
        if (!wr_q) rdata_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_SREQ: begin
        cnt_d = cnt_inc;
        // Ack is tested first so a late ack on the timeout cycle still completes cleanly.
        if (ack_w) begin
          if (!wr_q) rdata_d = sdata_w;
          state_d = ST_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdata_d = DATA_W'(TIMEOUT_RDATA);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so every port comes straight from a flop.
  always_comb begin
    ready_d = (state_d == ST_RESP);
    wem_d   = (state_d == ST_MEM) && wr_d;
    sel_d   = '0;
    we_d    = '0;
    ridx_d  = '0;
    if (state_d == ST_SREQ) begin
      sel_d  = NUM_SLAVES'(1) << slave_d;
      we_d   = wr_d ? sel_d : '0;
      ridx_d = idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      slave_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      wem_q   <= 1'b0;
      sel_q   <= '0;
      we_q    <= '0;
      ridx_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      slave_q <= slave_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      wem_q   <= wem_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ridx_q  <= ridx_d;
    end
  end

  assign ready   = ready_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign WEM     = wem_q;
  assign sel     = sel_q;
  assign we      = we_q;
  assign reg_idx = ridx_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Transaction-level reference bench for mmio_bus_decoder: random and directed loads/stores.
module tb_mmio_bus_decoder;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          memWrite;
  logic [31:0]   Addr;
  logic          ready;
  logic          err;
  logic [31:0]   rdata;
  logic          WEM;
  logic [31:0]   mem_rdata;
  logic [3:0]    sel;
  logic [3:0]    we;
  logic [1:0]    reg_idx;
  logic [127:0]  slv_rdata;
  logic [3:0]    slv_ack;

  int n_chk;
  int n_err;

  bit          chk_en;
  logic        exp_ready;
  logic        exp_err;
  logic        exp_wem;
  logic [3:0]  exp_sel;
  logic [3:0]  exp_we;
  logic [1:0]  exp_ridx;
  logic [31:0] exp_rdata;
  logic [31:0] model_rdata;

  mmio_bus_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .memWrite  (memWrite),
    .Addr      (Addr),
    .ready     (ready),
    .err       (err),
    .rdata     (rdata),
    .WEM       (WEM),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .we        (we),
    .reg_idx   (reg_idx),
    .slv_rdata (slv_rdata),
    .slv_ack   (slv_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'b0, ready}, {31'b0, exp_ready});
      chk("WEM", {31'b0, WEM}, {31'b0, exp_wem});
      chk("sel", {28'b0, sel}, {28'b0, exp_sel});
      chk("we", {28'b0, we}, {28'b0, exp_we});
      chk("reg_idx", {30'b0, reg_idx}, {30'b0, exp_ridx});
      chk("rdata", rdata, exp_rdata);
      if (exp_ready) chk("err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  task automatic set_idle_exp();
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_wem   = 1'b0;
    exp_sel   = 4'b0;
    exp_we    = 4'b0;
    exp_ridx  = 2'b0;
    exp_rdata = model_rdata;
  endtask

  task automatic drive_noise();
    mem_rdata = $urandom;
    slv_rdata = {$urandom, $urandom, $urandom, $urandom};
    slv_ack   = 4'($urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req = 1'b0;
    drive_noise();
    set_idle_exp();
  endtask

  // ackcyc: SREQ cycle (1-based) in which the selected slave acks; above 15 means never.
  task automatic run_txn(input logic [31:0] a, input bit wr, input int ackcyc,
                         input bit fix_dat, input logic [31:0] fdat,
                         output int lat, output int wem_n, output logic [3:0] sel_or,
                         output int we_n, output logic [1:0] ridx_seen, output logic err_seen);
    bit          hit;
    int          slv;
    int          idx;
    int          kind;
    int          len;
    bit          err_e;
    logic [31:0] newr;
    logic [31:0] off;
    hit  = (a >= 32'd60) && (a < 32'd76);
    off  = a - 32'd60;
    slv  = hit ? int'(off / 4) : 0;
    idx  = hit ? int'(off % 4) : 0;
    if (!hit) begin
      kind = 0; len = 2; err_e = 1'b0;
    end else if (wr && (idx >= 2)) begin
      kind = 1; len = 1; err_e = 1'b1;
    end else if (ackcyc <= 15) begin
      kind = 2; len = ackcyc + 1; err_e = 1'b0;
    end else begin
      kind = 2; len = 16; err_e = 1'b1;
    end
    newr = model_rdata;
    lat = 0; wem_n = 0; sel_or = 4'b0; we_n = 0; ridx_seen = 2'b0; err_seen = 1'b0;

    @(posedge clk); #1;
    req = 1'b1; Addr = a; memWrite = wr;
    drive_noise();
    set_idle_exp();

    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      drive_noise();
      set_idle_exp();
      if (kind == 2 && k < len) begin
        slv_ack[slv] = (k == ackcyc);
        exp_sel  = 4'b0001 << slv;
        exp_we   = wr ? exp_sel : 4'b0;
        exp_ridx = 2'(idx);
        if (k == ackcyc) begin
          if (fix_dat) slv_rdata[slv*32 +: 32] = fdat;
          if (!wr) newr = slv_rdata[slv*32 +: 32];
        end
      end
      if (kind == 0 && k == 1) begin
        exp_wem = wr;
        if (!wr) newr = mem_rdata;
      end
      if (k == len) begin
        if (kind == 2 && err_e) newr = 32'h0;
        model_rdata = newr;
        exp_ready   = 1'b1;
        exp_err     = err_e;
        exp_rdata   = newr;
      end
      #3;
      if (ready) begin lat = k; err_seen = err; end
      wem_n  += int'(WEM);
      sel_or |= sel;
      if (we != 4'b0) we_n++;
      if (sel != 4'b0) ridx_seen = reg_idx;
    end
  endtask

  initial begin
    int          lat;
    int          wem_n;
    logic [3:0]  sel_or;
    int          we_n;
    logic [1:0]  ridx_seen;
    logic        err_seen;
    n_chk = 0; n_err = 0; chk_en = 1'b0;
    rst_n = 1'b0; req = 1'b0; memWrite = 1'b0; Addr = '0;
    mem_rdata = '0; slv_rdata = '0; slv_ack = '0;
    model_rdata = '0;
    set_idle_exp();

    repeat (2) @(negedge clk);
    chk("rst ready", {31'b0, ready}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst WEM", {31'b0, WEM}, 32'd0);
    chk("rst sel", {28'b0, sel}, 32'd0);
    chk("rst we", {28'b0, we}, 32'd0);
    chk("rst reg_idx", {30'b0, reg_idx}, 32'd0);
    chk("rst rdata", rdata, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    idle_cycle();
    run_txn(32'd100, 1'b1, 0, 1'b0, 32'h0, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("store100 latency", lat, 32'd2);
    chk("store100 WEM cycles", wem_n, 32'd1);
    chk("store100 sel", {28'b0, sel_or}, 32'd0);
    idle_cycle();

    run_txn(32'd62, 1'b0, 1, 1'b1, 32'h0000_00A5, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("load62 latency", lat, 32'd2);
    chk("load62 sel", {28'b0, sel_or}, 32'b0001);
    chk("load62 we cycles", we_n, 32'd0);
    chk("load62 reg_idx", {30'b0, ridx_seen}, 32'd2);
    chk("load62 rdata", rdata, 32'h0000_00A5);
    idle_cycle();

    run_txn(32'd65, 1'b1, 4, 1'b0, 32'h0, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("store65 latency", lat, 32'd5);
    chk("store65 sel", {28'b0, sel_or}, 32'b0010);
    chk("store65 we cycles", we_n, 32'd4);
    chk("store65 err", {31'b0, err_seen}, 32'd0);
    chk("store65 rdata kept", rdata, 32'h0000_00A5);
    idle_cycle();

    run_txn(32'd63, 1'b1, 1, 1'b0, 32'h0, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("prot63 latency", lat, 32'd1);
    chk("prot63 sel", {28'b0, sel_or}, 32'd0);
    chk("prot63 err", {31'b0, err_seen}, 32'd1);

    run_txn(32'd70, 1'b0, 99, 1'b0, 32'h0, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("timeout70 latency", lat, 32'd16);
    chk("timeout70 err", {31'b0, err_seen}, 32'd1);
    chk("timeout70 rdata", rdata, 32'd0);
    idle_cycle();

    run_txn(32'd66, 1'b0, 15, 1'b1, 32'h1234_5678, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("ack-at-timeout latency", lat, 32'd16);
    chk("ack-at-timeout err", {31'b0, err_seen}, 32'd0);
    chk("ack-at-timeout rdata", rdata, 32'h1234_5678);
    idle_cycle();

    // Reset in the middle of a slave access
    @(posedge clk); #1;
    req = 1'b1; Addr = 32'd70; memWrite = 1'b0; slv_ack = 4'b0;
    set_idle_exp();
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      slv_ack = 4'b0;
      set_idle_exp();
      exp_sel  = 4'b0100;
      exp_ridx = 2'd2;
    end
    #6;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    req    = 1'b0;
    #1;
    chk("midrst ready", {31'b0, ready}, 32'd0);
    chk("midrst sel", {28'b0, sel}, 32'd0);
    chk("midrst we", {28'b0, we}, 32'd0);
    chk("midrst WEM", {31'b0, WEM}, 32'd0);
    chk("midrst reg_idx", {30'b0, reg_idx}, 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_rdata = '0;
    set_idle_exp();
    chk_en = 1'b1;
    run_txn(32'd59, 1'b0, 0, 1'b0, 32'h0, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
    chk("load59 latency", lat, 32'd2);
    chk("load59 sel", {28'b0, sel_or}, 32'd0);
    idle_cycle();

    for (int t = 0; t < 300; t++) begin
      int          r;
      int          rac;
      int          ac;
      bit          wr;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 2)      a = $urandom;
      else if (r < 3) a = $urandom_range(56, 80);
      else            a = $urandom_range(60, 75);
      wr  = 1'($urandom_range(0, 1));
      rac = int'($urandom_range(0, 9));
      if (rac < 6)      ac = int'($urandom_range(1, 5));
      else if (rac < 8) ac = int'($urandom_range(13, 16));
      else              ac = 99;
      run_txn(a, wr, ac, 1'b0, 32'h0, lat, wem_n, sel_or, we_n, ridx_seen, err_seen);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    idle_cycle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
